// File: rtl/ofm_addr_controller.sv
// OFM write-address generator: emits one channel-planar, row-major word address per
// accepted write in tile-scan order (pix, ch, col_tile, row), registered with a valid flag.
module ofm_addr_controller #(
    parameter int ADDR_WIDTH    = 22,
    parameter int SYSTOLIC_SIZE = 16,
    parameter int OFM_SIZE      = 416
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write,
    output logic [ADDR_WIDTH-1:0] ofm_addr,
    output logic                  addr_valid
);
    localparam int TILES  = OFM_SIZE / SYSTOLIC_SIZE;
    localparam int PIX_W  = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
    localparam int TILE_W = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int ROW_W  = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;

    localparam logic [ADDR_WIDTH-1:0] CH_STEP  = ADDR_WIDTH'(OFM_SIZE * OFM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(OFM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] COL_STEP = ADDR_WIDTH'(SYSTOLIC_SIZE);

    logic [PIX_W-1:0]      pix, ch;
    logic [TILE_W-1:0]     col_tile;
    logic [ROW_W-1:0]      row;
    logic [ADDR_WIDTH-1:0] ch_base, row_base, col_base;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  pix_last, ch_last, col_last, row_last;

    // Running bases replace the ch/row/col multiplies; wraps are modulo 2^ADDR_WIDTH.
    assign cur_addr = ch_base + row_base + col_base + ADDR_WIDTH'(pix);

    assign pix_last = (pix == PIX_W'(SYSTOLIC_SIZE - 1));
    assign ch_last  = (ch == PIX_W'(SYSTOLIC_SIZE - 1));
    assign col_last = (col_tile == TILE_W'(TILES - 1));
    assign row_last = (row == ROW_W'(OFM_SIZE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix        <= '0;
            ch         <= '0;
            col_tile   <= '0;
            row        <= '0;
            ch_base    <= '0;
            row_base   <= '0;
            col_base   <= '0;
            ofm_addr   <= '0;
            addr_valid <= 1'b0;
        end else if (write) begin
            ofm_addr   <= cur_addr;
            addr_valid <= 1'b1;
            if (!pix_last) begin
                pix <= pix + 1'b1;
            end else begin
                pix <= '0;
                if (!ch_last) begin
                    ch      <= ch + 1'b1;
                    ch_base <= ch_base + CH_STEP;
                end else begin
                    ch      <= '0;
                    ch_base <= '0;
                    if (!col_last) begin
                        col_tile <= col_tile + 1'b1;
                        col_base <= col_base + COL_STEP;
                    end else begin
                        col_tile <= '0;
                        col_base <= '0;
                        // Last row wraps everything, restarting the frame at address 0.
                        if (!row_last) begin
                            row      <= row + 1'b1;
                            row_base <= row_base + ROW_STEP;
                        end else begin
                            row      <= '0;
                            row_base <= '0;
                        end
                    end
                end
            end
        end else begin
            addr_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ofm_addr_controller.sv
// Directed bench for ofm_addr_controller: default-size instance for scan order and
// pause/reset behaviour, plus a small instance (4x4 array, 8x8 map) for a full-frame wrap.
module tb_ofm_addr_controller;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        write;
    logic        write_s;
    logic [21:0] ofm_addr, ofm_addr_s;
    logic        addr_valid, addr_valid_s;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ofm_addr_controller #(.ADDR_WIDTH(22), .SYSTOLIC_SIZE(16), .OFM_SIZE(416)) dut (
        .clk(clk), .rst_n(rst_n), .write(write),
        .ofm_addr(ofm_addr), .addr_valid(addr_valid)
    );

    ofm_addr_controller #(.ADDR_WIDTH(22), .SYSTOLIC_SIZE(4), .OFM_SIZE(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .write(write_s),
        .ofm_addr(ofm_addr_s), .addr_valid(addr_valid_s)
    );

    typedef struct {
        int          idx;   // 1-based write number
        logic [21:0] addr;  // address expected for that write
    } vec_t;

    vec_t main_vec[9];
    vec_t small_vec[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Drive write inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic w, input logic ws);
        write   = w;
        write_s = ws;
        @(posedge clk);
        #1;
    endtask

    // Hold reset across edges with write asserted; outputs must stay cleared.
    task automatic do_reset();
        write   = 1'b1;
        write_s = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_addr", 32'(ofm_addr), 0);
        chk("reset_valid", 32'(addr_valid), 0);
        write   = 1'b0;
        write_s = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int t;
        int vcnt;

        main_vec[0] = '{1, 22'd0};
        main_vec[1] = '{2, 22'd1};
        main_vec[2] = '{16, 22'd15};
        main_vec[3] = '{17, 22'd173056};
        main_vec[4] = '{20, 22'd173059};
        main_vec[5] = '{256, 22'd2595855};
        main_vec[6] = '{257, 22'd16};
        main_vec[7] = '{6656, 22'd2596255};
        main_vec[8] = '{6657, 22'd416};

        small_vec[0] = '{1, 22'd0};
        small_vec[1] = '{4, 22'd3};
        small_vec[2] = '{5, 22'd64};
        small_vec[3] = '{16, 22'd195};
        small_vec[4] = '{17, 22'd4};
        small_vec[5] = '{32, 22'd199};
        small_vec[6] = '{33, 22'd8};
        small_vec[7] = '{256, 22'd255};
        small_vec[8] = '{257, 22'd0};

        write   = 1'b0;
        write_s = 1'b0;
        rst_n   = 1'b0;
        #2;
        chk("por_addr", 32'(ofm_addr), 0);
        chk("por_valid", 32'(addr_valid), 0);

        // Continuous scan through pixel, channel, column-tile and row wraps.
        do_reset();
        chk("pre_write_valid", 32'(addr_valid), 0);
        t = 0;
        vcnt = 0;
        for (int i = 1; i <= 6657; i++) begin
            step(1'b1, 1'b0);
            if (addr_valid) vcnt++;
            if (t < 9 && main_vec[t].idx == i) begin
                chk($sformatf("scan_addr_w%0d", i), 32'(ofm_addr), 32'(main_vec[t].addr));
                t++;
            end
        end
        chk("scan_valid_count", 32'(vcnt), 6657);
        step(1'b0, 1'b0);
        chk("scan_valid_drop", 32'(addr_valid), 0);
        chk("scan_addr_hold", 32'(ofm_addr), 416);

        // Pause and resume: 50th write is ch 3, pix 1.
        do_reset();
        repeat (50) step(1'b1, 1'b0);
        chk("pause_w50", 32'(ofm_addr), 519169);
        step(1'b0, 1'b0);
        chk("gap_first_valid", 32'(addr_valid), 0);
        chk("gap_first_addr", 32'(ofm_addr), 519169);
        repeat (9) step(1'b0, 1'b0);
        chk("gap_last_valid", 32'(addr_valid), 0);
        chk("gap_last_addr", 32'(ofm_addr), 519169);
        step(1'b1, 1'b0);
        chk("resume_addr", 32'(ofm_addr), 519170);
        chk("resume_valid", 32'(addr_valid), 1);

        // Mid-frame asynchronous reset after 300 writes (ch 2, col_tile 1, pix 11).
        do_reset();
        repeat (300) step(1'b1, 1'b0);
        chk("pre_rst_w300", 32'(ofm_addr), 346139);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_addr", 32'(ofm_addr), 0);
        chk("async_rst_valid", 32'(addr_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0);
        chk("post_rst_first", 32'(ofm_addr), 0);
        chk("post_rst_valid", 32'(addr_valid), 1);
        step(1'b1, 1'b0);
        chk("post_rst_second", 32'(ofm_addr), 1);

        // Full frame on the small instance: 8*8*4 = 256 writes, then back to 0.
        do_reset();
        t = 0;
        vcnt = 0;
        for (int i = 1; i <= 257; i++) begin
            step(1'b0, 1'b1);
            if (addr_valid_s) vcnt++;
            if (t < 9 && small_vec[t].idx == i) begin
                chk($sformatf("frame_addr_w%0d", i), 32'(ofm_addr_s), 32'(small_vec[t].addr));
                t++;
            end
        end
        chk("frame_valid_count", 32'(vcnt), 257);
        step(1'b0, 1'b1);
        chk("frame_restart_w258", 32'(ofm_addr_s), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
